// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory port between core and loader
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            rr_ptr;
  logic            cmd_id;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW-1:0]   rdata0_q;
  logic [DW-1:0]   rdata1_q;

  logic            grant_valid;
  logic            grant_id;

  // State register; reset drops straight to IDLE so mem_we falls with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, winner selection and per-state outputs.
  always_comb begin
    state_next  = state;
    grant_valid = 1'b0;
    grant_id    = rr_ptr;
    mem_we      = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req0 || req1) begin
          grant_valid = 1'b1;
          // A lone requester always wins; a tie goes to the port rr_ptr names.
          grant_id    = (req0 && req1) ? rr_ptr : req1;
          state_next  = ACCESS;
        end
      end
      ACCESS: begin
        mem_we     = cmd_we;
        state_next = RESP;
      end
      RESP: begin
        ack0       = ~cmd_id;
        ack1       = cmd_id;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch, read-data capture and fairness pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (grant_valid) begin
        cmd_id    <= grant_id;
        cmd_we    <= grant_id ? we1    : we0;
        cmd_addr  <= grant_id ? addr1  : addr0;
        cmd_wdata <= grant_id ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        // Stores capture too: the winner sees the pre-write contents.
        if (cmd_id) begin
          rdata1_q <= mem_rd;
        end else begin
          rdata0_q <= mem_rd;
        end
        rr_ptr <= ~cmd_id;
      end
    end
  end

  // The memory bus follows the latched command, holding it outside ACCESS.
  assign mem_a  = cmd_addr;
  assign mem_wd = cmd_wdata;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
`timescale 1ns/1ps

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        ack0;
  logic [31:0] rdata0;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ack1;
  logic [31:0] rdata1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        busy;

  logic        poke = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  logic [31:0] tbmem   [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rd  [0:1];
  int          exp_ptr = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write on the rising edge.
  assign mem_rd = tbmem[mem_a[7:2]];
  always @(posedge clk) begin
    if (poke) tbmem[poke_idx] <= poke_val;
    if (mem_we) tbmem[mem_a[7:2]] <= mem_wd;
  end

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    poke = 1'b1; poke_idx = a[7:2]; poke_val = v;
    ref_mem[a[7:2]] = v;
    @(negedge clk);
    poke = 1'b0;
  endtask

  // Reference: transactions are serialized; the winner sees the old word, a store then updates it.
  task automatic model_complete(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_rd[p] = ref_mem[a[7:2]];
    if (w) ref_mem[a[7:2]] = d;
    exp_ptr = 1 - p;
  endtask

  task automatic check_rdata(input string tag);
    checks++;
    if (rdata0 !== exp_rd[0]) begin
      errors++; $display("FAIL %s rdata0 got %h want %h", tag, rdata0, exp_rd[0]);
    end
    checks++;
    if (rdata1 !== exp_rd[1]) begin
      errors++; $display("FAIL %s rdata1 got %h want %h", tag, rdata1, exp_rd[1]);
    end
  endtask

  task automatic run_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    int   cyc = 0, we_cyc = 0, stray = 0;
    logic got = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, w, a, d);
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_we) we_cyc++;
      if (p == 0 ? ack1 : ack0) stray++;
      if (p == 0 ? ack0 : ack1) got = 1'b1;
    end
    drive(p, 1'b0, 1'b0, a, d);
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s ack timeout after %0d cycles want 2", tag, cyc);
    end else begin
      model_complete(p, w, a, d);
      checks++;
      if (cyc != 2) begin errors++; $display("FAIL %s latency got %0d want 2", tag, cyc); end
      checks++;
      if (we_cyc != int'(w)) begin errors++; $display("FAIL %s mem_we cycles got %0d want %0d", tag, we_cyc, int'(w)); end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL %s stray acks got %0d want 0", tag, stray); end
      check_rdata(tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) poke_word(32'(i) << 2, $urandom);
    exp_rd[0] = '0; exp_rd[1] = '0; exp_ptr = 0;
    checks++;
    if ({ack0, ack1, mem_we, busy} !== 4'b0 || mem_a !== '0 || mem_wd !== '0) begin
      errors++; $display("FAIL reset outputs got ack0=%b ack1=%b we=%b busy=%b a=%h wd=%h want 0",
                         ack0, ack1, mem_we, busy, mem_a, mem_wd);
    end
    check_rdata("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_basic();
    poke_word(32'h60, 32'hDEADBEEF);
    run_txn(0, 1'b0, 32'h60, 32'h0, "load_basic");
    checks++;
    if (rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_basic rdata0 got %h want deadbeef", rdata0); end
  endtask

  task automatic test_store_load();
    run_txn(1, 1'b1, 32'h64, 32'h12345678, "store_p1");
    run_txn(0, 1'b0, 32'h64, 32'h0, "load_p0");
    checks++;
    if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL store_load rdata0 got %h want 12345678", rdata0); end
  endtask

  // Both ports request continuously, re-issuing a new command after each ack.
  task automatic test_fairness(input int n, input logic from_reset, input logic allow_store, input string tag);
    logic [31:0] a [0:1];
    logic [31:0] d [0:1];
    logic        w [0:1];
    int          acks = 0, cyc = 0, last = -1, p;
    for (int i = 0; i < 2; i++) begin
      a[i] = rand_addr(); d[i] = $urandom; w[i] = allow_store ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    if (from_reset) reset = 1'b0;
    drive(0, 1'b1, w[0], a[0], d[0]);
    drive(1, 1'b1, w[1], a[1], d[1]);
    if (from_reset) begin
      exp_rd[0] = '0; exp_rd[1] = '0; exp_ptr = 0;
      @(negedge clk);
      reset = 1'b1;
    end
    while (acks < n && cyc < 12 * n) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (ack0 && ack1) begin errors++; $display("FAIL %s both acks high at cycle %0d", tag, cyc); end
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        checks++;
        if (p != exp_ptr) begin errors++; $display("FAIL %s grant order got port %0d want %0d", tag, p, exp_ptr); end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin errors++; $display("FAIL %s ack spacing got %0d want 3", tag, cyc - last); end
        end
        last = cyc;
        model_complete(p, w[p], a[p], d[p]);
        check_rdata(tag);
        acks++;
        a[p] = rand_addr(); d[p] = $urandom; w[p] = allow_store ? 1'($urandom_range(0, 1)) : 1'b0;
        drive(p, 1'b1, w[p], a[p], d[p]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (acks != n) begin errors++; $display("FAIL %s acks got %0d want %0d", tag, acks, n); end
  endtask

  task automatic test_addr_change();
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h60, 32'h0);
    @(negedge clk);
    checks++;
    if (mem_a !== 32'h60 || mem_we !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL addr_change access a=%h we=%b busy=%b want 60 0 1", mem_a, mem_we, busy);
    end
    addr0 = 32'h70;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || mem_a !== 32'h60) begin
      errors++; $display("FAIL addr_change resp ack0=%b a=%h want 1 60", ack0, mem_a);
    end
    model_complete(0, 1'b0, 32'h60, 32'h0);
    check_rdata("addr_change");
    drive(0, 1'b0, 1'b0, 32'h70, 32'h0);
  endtask

  task automatic test_random_singles(input int n);
    for (int i = 0; i < n; i++) begin
      run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), $urandom, "random_single");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    a = rand_addr();
    run_txn(0, 1'b0, rand_addr(), 32'h0, "pre_reset");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, a, ~ref_mem[a[7:2]]);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL reset_mid store we got %b want 1", mem_we); end
    #2 reset = 1'b0;
    #1;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_ptr = 0;
    checks++;
    if ({ack0, ack1, mem_we, busy} !== 4'b0 || mem_a !== '0 || mem_wd !== '0) begin
      errors++; $display("FAIL reset_mid outputs ack0=%b ack1=%b we=%b busy=%b a=%h wd=%h want 0",
                         ack0, ack1, mem_we, busy, mem_a, mem_wd);
    end
    check_rdata("reset_mid");
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_mid lost ack got %b want 0", ack0); end
    reset = 1'b1;
    test_fairness(2, 1'b0, 1'b0, "post_reset_rr");
    run_txn(1, 1'b0, a, 32'h0, "reset_no_write");
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_we !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        bad++; errors++;
        $display("FAIL idle cycle %0d busy=%b we=%b ack0=%b ack1=%b want 0", i, busy, mem_we, ack0, ack1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_load();
    test_fairness(6, 1'b1, 1'b0, "rr_loads");
    test_fairness(10, 1'b0, 1'b1, "rr_mixed");
    test_addr_change();
    test_random_singles(20);
    test_reset_mid();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
